// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back scheduler state, also used by the register file and decode.
package regfile_pkg;

  localparam int W  = 32;
  localparam int AW = 3;

  localparam logic [AW-1:0] REG_LR = 3'd6;
  localparam logic [AW-1:0] REG_PC = 3'd7;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic is_pc(input logic [AW-1:0] addr);
    return addr == REG_PC;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back requester handshakes plus the register-file write port driven by the scheduler.
interface regfile_wb_scheduler_if #(
  parameter int W  = 32,
  parameter int AW = 3
);

  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [W-1:0]  alu_data;
  logic          alu_ready;

  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic          mem_ready;

  logic          link_req;
  logic          flush;

  logic          rf_we;
  logic [AW-1:0] rf_add3;
  logic [W-1:0]  rf_in;
  logic          rf_lrwrite;
  logic          busy;
  logic          err_pc_write;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output link_req, flush,
    input  alu_ready, mem_ready,
    input  rf_we, rf_add3, rf_in, rf_lrwrite, busy, err_pc_write
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  link_req, flush,
    output alu_ready, mem_ready,
    output rf_we, rf_add3, rf_in, rf_lrwrite, busy, err_pc_write
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter, combinational grant; bit 0 = ALU, bit 1 = load.
// Masked requesters are invisible; a tie goes to whichever side was not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic       last_alu;
  logic [1:0] elig;

  always_comb begin
    elig = req & ~mask;
    gnt  = elig;
    if (elig == 2'b11) begin
      gnt = last_alu ? 2'b10 : 2'b01;
    end
  end

  // Cleared pointer means "load went last", so the first tie after reset favours the ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_alu <= 1'b0;
    end else if (advance) begin
      last_alu <= gnt[0];
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Single write port scheduler for the register file: one-cycle registered write-back, LR link updates, PC write blocking.
// Requesters see combinational ready; flush or a pending link to LR holds them off until the write can issue.
module regfile_wb_scheduler #(
  parameter int                W      = regfile_pkg::W,
  parameter int                AW     = regfile_pkg::AW,
  parameter logic [AW-1:0]     PC_REG = regfile_pkg::REG_PC,
  parameter logic [AW-1:0]     LR_REG = regfile_pkg::REG_LR
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_scheduler_if.slave bus
);

  import regfile_pkg::state_t;
  import regfile_pkg::RUN;
  import regfile_pkg::DRAIN;

  state_t        state, state_nxt;
  logic          link_pending, link_pending_nxt;
  logic          accept_en;
  logic          link_issue;
  logic [1:0]    req, mask, gnt;
  logic          sel_vld;
  logic [AW-1:0] sel_addr;
  logic [W-1:0]  sel_data;
  logic          wr_ok;

  logic          rf_we_q;
  logic [AW-1:0] rf_add3_q;
  logic [W-1:0]  rf_in_q;
  logic          rf_lrwrite_q;
  logic          err_q;

  // A link request issues in its own cycle, so LR-targeted data must yield to it right away.
  always_comb begin
    accept_en  = (state == RUN) && !bus.flush;
    link_issue = accept_en && (link_pending || bus.link_req);
    req        = {bus.mem_valid, bus.alu_valid};
    mask[0]    = !accept_en || (link_issue && (bus.alu_addr == LR_REG));
    mask[1]    = !accept_en || (link_issue && (bus.mem_addr == LR_REG));
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask    (mask),
    .advance (sel_vld),
    .gnt     (gnt)
  );

  always_comb begin
    sel_vld  = |gnt;
    sel_addr = gnt[1] ? bus.mem_addr : bus.alu_addr;
    sel_data = gnt[1] ? bus.mem_data : bus.alu_data;
    wr_ok    = sel_vld && (sel_addr != PC_REG);
  end

  always_comb begin
    state_nxt        = state;
    link_pending_nxt = link_pending;

    if (state == RUN) begin
      if (bus.flush) state_nxt = DRAIN;
    end else begin
      if (!bus.flush && !rf_we_q) state_nxt = RUN;
    end

    if (bus.flush) begin
      link_pending_nxt = 1'b0;
    end else if (link_issue) begin
      link_pending_nxt = 1'b0;
    end else if (bus.link_req) begin
      link_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      link_pending <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_add3_q    <= '0;
      rf_in_q      <= '0;
      rf_lrwrite_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      link_pending <= link_pending_nxt;
      rf_we_q      <= wr_ok;
      rf_lrwrite_q <= link_issue;
      // Address/data hold their last value on idle cycles; only real writes move them.
      if (wr_ok) begin
        rf_add3_q <= sel_addr;
        rf_in_q   <= sel_data;
      end
      if (sel_vld && (sel_addr == PC_REG)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.alu_ready    = gnt[0];
  assign bus.mem_ready    = gnt[1];
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_add3      = rf_add3_q;
  assign bus.rf_in        = rf_in_q;
  assign bus.rf_lrwrite   = rf_lrwrite_q;
  assign bus.busy         = link_pending | rf_we_q | rf_lrwrite_q;
  assign bus.err_pc_write = err_q;

  a_one_ready: assert property (@(posedge clk) disable iff (!rst)
    !(bus.alu_ready && bus.mem_ready));

  a_no_pc_we: assert property (@(posedge clk) disable iff (!rst)
    rf_we_q |-> (rf_add3_q != PC_REG));

  a_drain_quiet: assert property (@(posedge clk) disable iff (!rst)
    (state == DRAIN) |-> !(bus.alu_ready || bus.mem_ready));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and random stimulus for regfile_wb_scheduler, compared every cycle against a behavioural model.
module tb_regfile_wb_scheduler;

  logic clk;
  logic rst;

  regfile_wb_scheduler_if ifc ();

  regfile_wb_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Requester registers: a request stays up, unchanged, until it is granted.
  bit        a_v, m_v;
  bit [2:0]  a_a, m_a;
  bit [31:0] a_d, m_d;

  // Model of what the register file must see.
  bit        md_drain, md_pend, md_last_alu, md_we, md_lr, md_err;
  bit [2:0]  md_add3;
  bit [31:0] md_in;

  // DUT readies/busy seen during the most recent cycle, for directed checks.
  logic obs_a_rdy, obs_m_rdy, obs_busy_pre;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    md_drain = 0; md_pend = 0; md_last_alu = 0;
    md_we = 0; md_lr = 0; md_err = 0; md_add3 = '0; md_in = '0;
    a_v = 0; m_v = 0;
  endtask

  task automatic drive_idle();
    ifc.alu_valid = 0; ifc.alu_addr = '0; ifc.alu_data = '0;
    ifc.mem_valid = 0; ifc.mem_addr = '0; ifc.mem_data = '0;
    ifc.link_req  = 0; ifc.flush = 0;
  endtask

  // One clock: called just after a falling edge, returns at the next falling edge.
  task automatic cycle(input bit lk, input bit fl, input string tag);
    bit run_ok, issue, a_ok, m_ok, a_g, m_g;
    bit [2:0]  wa;
    bit [31:0] wd;
    ifc.alu_valid = a_v; ifc.alu_addr = a_a; ifc.alu_data = a_d;
    ifc.mem_valid = m_v; ifc.mem_addr = m_a; ifc.mem_data = m_d;
    ifc.link_req  = lk;  ifc.flush    = fl;
    #1;
    run_ok = !md_drain && !fl;
    issue  = run_ok && (md_pend || lk);
    a_ok   = a_v && run_ok && !(issue && a_a == 3'd6);
    m_ok   = m_v && run_ok && !(issue && m_a == 3'd6);
    a_g    = a_ok && !(m_ok && md_last_alu);
    m_g    = m_ok && !a_g;
    obs_a_rdy    = ifc.alu_ready;
    obs_m_rdy    = ifc.mem_ready;
    obs_busy_pre = ifc.busy;
    check_eq({tag, ".alu_ready"}, ifc.alu_ready, a_g);
    check_eq({tag, ".mem_ready"}, ifc.mem_ready, m_g);
    check_eq({tag, ".busy_pre"},  ifc.busy, md_pend | md_we | md_lr);

    md_drain = md_drain ? (fl || md_we) : fl;
    md_pend  = fl ? 1'b0 : (issue ? 1'b0 : (lk ? 1'b1 : md_pend));
    md_lr    = issue;
    md_we    = 0;
    if (a_g || m_g) begin
      wa = a_g ? a_a : m_a;
      wd = a_g ? a_d : m_d;
      md_last_alu = a_g;
      if (wa == 3'd7) md_err = 1;
      else begin
        md_we = 1; md_add3 = wa; md_in = wd;
      end
    end
    if (a_g) a_v = 0;
    if (m_g) m_v = 0;

    @(posedge clk);
    #1;
    check_eq({tag, ".rf_we"},      ifc.rf_we, md_we);
    check_eq({tag, ".rf_lrwrite"}, ifc.rf_lrwrite, md_lr);
    check_eq({tag, ".rf_add3"},    ifc.rf_add3, md_add3);
    check_eq({tag, ".rf_in"},      ifc.rf_in, md_in);
    check_eq({tag, ".err_pc"},     ifc.err_pc_write, md_err);
    check_eq({tag, ".busy"},       ifc.busy, md_pend | md_we | md_lr);
    @(negedge clk);
  endtask

  // Pull reset low between edges while a write is showing, then release on a falling edge.
  task automatic reset_mid_write(input string tag);
    #2 rst = 1'b0;
    #1;
    check_eq({tag, ".rf_we"},      ifc.rf_we, 0);
    check_eq({tag, ".rf_add3"},    ifc.rf_add3, 0);
    check_eq({tag, ".rf_in"},      ifc.rf_in, 0);
    check_eq({tag, ".rf_lrwrite"}, ifc.rf_lrwrite, 0);
    check_eq({tag, ".err_pc"},     ifc.err_pc_write, 0);
    check_eq({tag, ".busy"},       ifc.busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic bit [2:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1) ? 3'd6 : 3'd7;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    int fl_cnt;
    bit lk, fl;
    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst.rf_we",   ifc.rf_we, 0);
    check_eq("rst.rf_add3", ifc.rf_add3, 0);
    check_eq("rst.rf_in",   ifc.rf_in, 0);
    check_eq("rst.lrwrite", ifc.rf_lrwrite, 0);
    check_eq("rst.err_pc",  ifc.err_pc_write, 0);
    check_eq("rst.busy",    ifc.busy, 0);
    rst = 1'b1;

    // Reset asserted while an ALU write is on the port; ALU must win the next tie again.
    a_v = 1; a_a = 3'd5; a_d = 32'h1;
    cycle(0, 0, "t1_pre");
    check_eq("t1.inflight_we", ifc.rf_we, 1);
    reset_mid_write("t1_async");

    // Ties alternate ALU, load, ALU.
    a_v = 1; a_a = 3'd2; a_d = 32'h11;
    m_v = 1; m_a = 3'd3; m_d = 32'h22;
    cycle(0, 0, "t2_c1");
    check_eq("t2.c1_alu_first", obs_a_rdy, 1);
    check_eq("t2.c1_add3", ifc.rf_add3, 2);
    check_eq("t2.c1_in",   ifc.rf_in, 32'h11);
    a_v = 1; a_a = 3'd4; a_d = 32'h44;
    cycle(0, 0, "t2_c2");
    check_eq("t2.c2_add3", ifc.rf_add3, 3);
    check_eq("t2.c2_in",   ifc.rf_in, 32'h22);
    m_v = 1; m_a = 3'd5; m_d = 32'h55;
    cycle(0, 0, "t2_c3");
    check_eq("t2.c3_alu_wins", obs_a_rdy, 1);
    cycle(0, 0, "t2_c4");

    // Link beats an ALU write to LR.
    a_v = 1; a_a = 3'd6; a_d = 32'hAB;
    cycle(1, 0, "t3_n");
    check_eq("t3.n_alu_held", obs_a_rdy, 0);
    check_eq("t3.n1_lrwrite", ifc.rf_lrwrite, 1);
    check_eq("t3.n1_we",      ifc.rf_we, 0);
    cycle(0, 0, "t3_n1");
    check_eq("t3.n2_we",   ifc.rf_we, 1);
    check_eq("t3.n2_add3", ifc.rf_add3, 6);
    check_eq("t3.n2_in",   ifc.rf_in, 32'hAB);

    // Link co-issues with a load to a non-LR register.
    m_v = 1; m_a = 3'd1; m_d = 32'h5;
    cycle(1, 0, "t4");
    check_eq("t4.lrwrite", ifc.rf_lrwrite, 1);
    check_eq("t4.we",      ifc.rf_we, 1);
    check_eq("t4.add3",    ifc.rf_add3, 1);

    // PC write accepted but dropped, error sticks.
    a_v = 1; a_a = 3'd7; a_d = 32'hDEAD;
    cycle(0, 0, "t5");
    check_eq("t5.alu_ready", obs_a_rdy, 1);
    check_eq("t5.we",        ifc.rf_we, 0);
    check_eq("t5.err",       ifc.err_pc_write, 1);
    cycle(0, 0, "t5_idle");
    check_eq("t5.err_hold", ifc.err_pc_write, 1);

    // Flush with a write in flight, then with a link pending.
    a_v = 1; a_a = 3'd2; a_d = 32'h33;
    cycle(0, 0, "t6_a0");
    a_v = 1; a_a = 3'd4; a_d = 32'h44;
    m_v = 1; m_a = 3'd5; m_d = 32'h55;
    cycle(1, 1, "t6_a");
    check_eq("t6.a_ready", obs_a_rdy | obs_m_rdy, 0);
    check_eq("t6.a_busy_inflight", obs_busy_pre, 1);
    check_eq("t6.a_lrwrite", ifc.rf_lrwrite, 0);
    check_eq("t6.a_busy_fell", ifc.busy, 0);
    cycle(1, 0, "t6_b");
    check_eq("t6.b_ready", obs_a_rdy | obs_m_rdy, 0);
    check_eq("t6.b_pending", ifc.busy, 1);
    cycle(0, 1, "t6_c");
    check_eq("t6.c_ready", obs_a_rdy | obs_m_rdy, 0);
    check_eq("t6.c_lrwrite", ifc.rf_lrwrite, 0);
    check_eq("t6.c_busy", ifc.busy, 0);
    cycle(0, 0, "t6_d");
    check_eq("t6.d_lrwrite", ifc.rf_lrwrite, 0);
    cycle(0, 0, "t6_e");
    check_eq("t6.e_accepts", obs_a_rdy | obs_m_rdy, 1);
    cycle(0, 0, "t6_f");

    // Random traffic with occasional flush bursts and one mid-run reset.
    fl_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (!a_v && $urandom_range(0, 2) != 0) begin
        a_v = 1; a_a = pick_addr(); a_d = $urandom;
      end
      if (!m_v && $urandom_range(0, 2) != 0) begin
        m_v = 1; m_a = pick_addr(); m_d = $urandom;
      end
      lk = ($urandom_range(0, 5) == 0);
      if (fl_cnt > 0) begin
        fl_cnt--; fl = 1;
      end else if ($urandom_range(0, 24) == 0) begin
        fl_cnt = $urandom_range(0, 3); fl = 1;
      end else begin
        fl = 0;
      end
      cycle(lk, fl, "rnd");
      if (i == 400 && ifc.rf_we) reset_mid_write("rnd_rst");
    end

    drive_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
